prob_pulse_gen: RTL and testbench
=================================

PROB_PULSE_GEN -- requirements
Module: prob_pulse_gen

Interface
REQ-001 Parameter N_STATES, default 8: number of basis-state amplitudes per frame; power of two, 2..64.
REQ-002 Parameter W, default 17: signed amplitude width.
REQ-003 Parameter FRAC, default 15: fraction bits; 1.0 = 2^FRAC.
REQ-004 Parameter UNIT, default 2_500_000: pulse length in cycles for probability 1.0.
REQ-005 Parameter GAP, default 5_500_000: low cycles before each slot pulse.
REQ-006 Parameter TAIL, default 11_000_000: low cycles after the last slot.
REQ-007 Parameter CNT_W, default 32: width of the timing counters.
REQ-008 Port clk  in  1  rising-edge clock.
REQ-009 Port rst_n  in  1  asynchronous active-low reset.
REQ-010 Port amp_valid  in  1  amplitude word valid.
REQ-011 Port amp_ready  out  1  block accepts the amplitude word.
REQ-012 Port amp_re, amp_im  in  W each  signed real and imaginary parts, Q(W-FRAC).FRAC.
REQ-013 Port amp_last  in  1  marks word N_STATES-1 of a frame.
REQ-014 Port start  in  1  single-cycle request to begin display.
REQ-015 Port cont  in  1  1 = repeat periods; 0 = one period per start.
REQ-016 Port sq  out  1  pulse-width display waveform.
REQ-017 Port sync  out  1  one-cycle marker at each period start.
REQ-018 Port slot  out  clog2(N_STATES)  index of the slot being displayed.
REQ-019 Port busy  out  1  high while a period is in progress.
REQ-020 Port frame_err  out  1  sticky; amp_last position mismatch.

Function
REQ-021 Two probability banks SHALL exist: active (displayed) and shadow (loading); each entry FRAC+1 bits unsigned.
REQ-022 A word SHALL transfer on a cycle with amp_valid and amp_ready both 1; amp_ready = NOT shadow_full.
REQ-023 Each word SHALL be processed as p = (re*re + im*im) >>> FRAC, saturated to 2^FRAC; p is written to shadow[idx] exactly 2 cycles after transfer.
REQ-024 idx SHALL increment per transfer; word N_STATES-1 SHALL set shadow_full (once its p is written) and return idx to 0.
REQ-025 If amp_last is 1 at idx != N_STATES-1, or 0 at idx = N_STATES-1, the block SHALL set frame_err, discard the partial frame, and reset idx to 0.
REQ-026 FSM states SHALL be IDLE, SYNC, GAPW, PULSE, TAILW.
REQ-027 IDLE: on start=1 or cont=1, and with active bank valid or shadow_full -> SYNC; otherwise remain.
REQ-028 On the SYNC entry cycle, if shadow_full, shadow SHALL be copied to active, shadow_full cleared and active marked valid; sync=1 for that cycle; slot=0; -> GAPW.
REQ-029 GAPW: sq=0 for exactly GAP cycles -> PULSE.
REQ-030 PULSE: len = (active[slot]*UNIT) >> FRAC (floor); sq=1 for len cycles; len=0 SHALL skip PULSE with no sq high cycle.
REQ-031 After PULSE, slot<N_STATES-1 -> slot+1, GAPW; else -> TAILW.
REQ-032 TAILW: sq=0 for TAIL cycles, then -> SYNC if cont=1, else IDLE.
REQ-033 Period length SHALL equal 1 + N_STATES*GAP + sum(len) + TAIL cycles.
REQ-034 busy=1 in every state except IDLE; start while busy SHALL be ignored.
REQ-035 Loading during display SHALL never alter the active bank; a swap SHALL occur only at SYNC.
REQ-036 Internal product and accumulator widths SHALL be sized so no intermediate overflows for any W-bit input.

Reset
REQ-037 rst_n low SHALL immediately force IDLE; sq, sync, busy, frame_err, slot = 0; idx = 0; shadow_full = 0; active invalid; amp_ready=1 from the first cycle after release.
REQ-038 Reset asserted mid-period or mid-frame SHALL discard all in-progress state; no sq high cycle SHALL occur after release until a new frame and start.

Verification (N_STATES=8, W=17, FRAC=15, UNIT=16, GAP=4, TAIL=8)
REQ-039 Frame with re=23170 (~0.7071) at slots 0,1, zeros elsewhere; start -> sync 1 cycle, sq high 7 cycles in slots 0 and 1 only, period 1+32+14+8=55 cycles.
REQ-040 re=-32768 (-1.0) at slot 3 plus im=16384 (0.5) at slot 5 -> pulses of 16 and 4 cycles; busy falls after one period with cont=0.
REQ-041 cont=1, second frame loaded mid-period -> the current period is unchanged, the next sync shows the new frame, amp_ready is 0 between load completion and the swap.
REQ-042 amp_last at idx 5 -> frame_err=1, partial frame discarded, the next complete frame loads normally.
REQ-043 rst_n pulsed low during PULSE of slot 2 -> sq=0 and busy=0 the same cycle; start after release is ignored until a frame is loaded.
REQ-044 re=im=32767 (p saturates to 32768) -> len=16; an all-zero frame -> sq never high, period 41 cycles.

Source files
------------

// File: rtl/prob_pulse_gen.sv
// Turns a frame of complex amplitudes into a pulse-width display: one sq pulse per basis state, length proportional to |amp|^2.
// Two-cycle squaring pipeline feeds a shadow bank; amp_ready drops while a complete frame waits for the next sync to swap it in.
module prob_pulse_gen #(
  parameter int N_STATES = 8,
  parameter int W        = 17,
  parameter int FRAC     = 15,
  parameter int UNIT     = 2_500_000,
  parameter int GAP      = 5_500_000,
  parameter int TAIL     = 11_000_000,
  parameter int CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        amp_valid,
  output logic                        amp_ready,
  input  logic signed [W-1:0]         amp_re,
  input  logic signed [W-1:0]         amp_im,
  input  logic                        amp_last,
  input  logic                        start,
  input  logic                        cont,
  output logic                        sq,
  output logic                        sync,
  output logic [$clog2(N_STATES)-1:0] slot,
  output logic                        busy,
  output logic                        frame_err
);

  localparam int SW  = $clog2(N_STATES);
  localparam int PW  = FRAC + 1;
  localparam int SQW = 2 * W + 1;
  localparam int LW  = PW + CNT_W;
  localparam logic [SW-1:0]  LAST_IDX = SW'(N_STATES - 1);
  localparam logic [PW-1:0]  P_ONE    = {1'b1, {FRAC{1'b0}}};

  typedef enum logic [2:0] {IDLE, SYNC, GAPW, PULSE, TAILW} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]      r_slot, w_slot_nxt;

  logic [SW-1:0]      r_idx;
  logic               r_s1_vld, r_s1_last, r_s2_vld, r_s2_last;
  logic [SW-1:0]      r_s1_idx, r_s2_idx;
  logic [SQW-1:0]     r_s1_sum;
  logic [PW-1:0]      r_s2_p;
  logic               r_shadow_full, r_act_vld, r_frame_err;
  logic [PW-1:0]      r_shadow [N_STATES];
  logic [PW-1:0]      r_active [N_STATES];

  logic               w_xfer, w_last_ok, w_fill_pend, w_swap;
  logic signed [2*W-1:0] w_re_x, w_im_x, w_re_sq, w_im_sq;
  logic [SQW-1:0]     w_sum, w_p_full;
  logic [PW-1:0]      w_p_sat;
  logic [LW-1:0]      w_prod;
  logic [CNT_W-1:0]   w_len;

  // Squares are formed at 2W bits and summed at 2W+1, so even (-2^(W-1))^2 twice cannot wrap.
  assign w_re_x   = {{W{amp_re[W-1]}}, amp_re};
  assign w_im_x   = {{W{amp_im[W-1]}}, amp_im};
  assign w_re_sq  = w_re_x * w_re_x;
  assign w_im_sq  = w_im_x * w_im_x;
  assign w_sum    = {1'b0, w_re_sq} + {1'b0, w_im_sq};
  assign w_p_full = r_s1_sum >> FRAC;
  assign w_p_sat  = (w_p_full > {{(SQW-PW){1'b0}}, P_ONE}) ? P_ONE : w_p_full[PW-1:0];

  assign w_xfer    = amp_valid & amp_ready;
  assign w_last_ok = (amp_last == (r_idx == LAST_IDX));
  // The last word still in the pipeline counts as full, so no word of the next frame can slip in before the flag is set.
  assign w_fill_pend = (r_s1_vld & r_s1_last) | (r_s2_vld & r_s2_last);
  assign amp_ready   = ~(r_shadow_full | w_fill_pend);
  assign w_swap      = (r_state == SYNC) & r_shadow_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_s1_vld      <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_idx      <= '0;
      r_s1_sum      <= '0;
      r_s2_vld      <= 1'b0;
      r_s2_last     <= 1'b0;
      r_s2_idx      <= '0;
      r_s2_p        <= '0;
      r_shadow_full <= 1'b0;
      r_act_vld     <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_s1_vld <= w_xfer & w_last_ok;
      if (w_xfer) begin
        r_s1_last <= amp_last;
        r_s1_idx  <= r_idx;
        r_s1_sum  <= w_sum;
        if (!w_last_ok) begin
          r_frame_err <= 1'b1;
          r_idx       <= '0;
        end else if (r_idx == LAST_IDX) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + SW'(1);
        end
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s2_idx  <= r_s1_idx;
      r_s2_p    <= w_p_sat;
      if (w_swap) begin
        r_shadow_full <= 1'b0;
        r_act_vld     <= 1'b1;
      end else if (r_s2_vld && r_s2_last) begin
        r_shadow_full <= 1'b1;
      end
    end
  end

  // Bank contents need no reset: r_act_vld and r_shadow_full guard every use.
  always_ff @(posedge clk) begin
    if (r_s2_vld) r_shadow[r_s2_idx] <= r_s2_p;
    if (w_swap)   r_active <= r_shadow;
  end

  assign w_prod = {{CNT_W{1'b0}}, r_active[r_slot]} * LW'(UNIT);
  assign w_len  = CNT_W'(w_prod >> FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slot_nxt  = r_slot;
    case (r_state)
      IDLE: begin
        if ((start | cont) && (r_act_vld | r_shadow_full)) w_state_nxt = SYNC;
      end
      SYNC: begin
        w_state_nxt = GAPW;
        w_cnt_nxt   = CNT_W'(GAP - 1);
        w_slot_nxt  = '0;
      end
      GAPW: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_len != '0) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = w_len - CNT_W'(1);
        end else if (r_slot == LAST_IDX) begin
          w_state_nxt = TAILW;
          w_cnt_nxt   = CNT_W'(TAIL - 1);
        end else begin
          w_slot_nxt = r_slot + SW'(1);
          w_cnt_nxt  = CNT_W'(GAP - 1);
        end
      end
      PULSE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_slot == LAST_IDX) begin
          w_state_nxt = TAILW;
          w_cnt_nxt   = CNT_W'(TAIL - 1);
        end else begin
          w_state_nxt = GAPW;
          w_slot_nxt  = r_slot + SW'(1);
          w_cnt_nxt   = CNT_W'(GAP - 1);
        end
      end
      TAILW: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        else             w_state_nxt = cont ? SYNC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Decoded straight from the state register so an asserted reset clears them without waiting for a clock.
  assign sq        = (r_state == PULSE);
  assign sync      = (r_state == SYNC);
  assign busy      = (r_state != IDLE);
  assign slot      = r_slot;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_prob_pulse_gen.sv
// Bench for prob_pulse_gen with small timing parameters: frame table, per-period scoreboard, and hand sequences for error, cont and reset.
module tb_prob_pulse_gen;

  localparam int N = 8;
  localparam int W = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic amp_valid = 1'b0;
  logic amp_last = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic signed [W-1:0] amp_re = '0;
  logic signed [W-1:0] amp_im = '0;
  logic amp_ready, sq, sync, busy, frame_err;
  logic [2:0] slot;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prob_pulse_gen #(
    .N_STATES(N), .W(W), .FRAC(15), .UNIT(16), .GAP(4), .TAIL(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .amp_valid(amp_valid), .amp_ready(amp_ready),
    .amp_re(amp_re), .amp_im(amp_im), .amp_last(amp_last), .start(start),
    .cont(cont), .sq(sq), .sync(sync), .slot(slot), .busy(busy), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [7:0][16:0] re;
    logic [7:0][16:0] im;
    logic [7:0][7:0]  len;
    logic [15:0]      period;
  } vec_t;

  typedef struct packed {
    logic [7:0][7:0] len;
    logic [15:0]     period;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input vec_t v);
    exp_t e;
    e.len = v.len;
    e.period = v.period;
    return e;
  endfunction

  // Monitor: measures each period (sync to next sync or busy fall) and compares against the scoreboard.
  int per_cyc = 0;
  int slot_hi[8];
  int sq_total = 0;
  int sync_cnt = 0;
  logic in_per = 1'b0;
  logic prev_sync = 1'b0;

  task automatic finish_period();
    exp_t e;
    chk("sb_expected_period", int'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int i = 0; i < 8; i++) chk($sformatf("slot%0d_len", i), slot_hi[i], int'(e.len[i]));
      chk("period_len", per_cyc, int'(e.period));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) slot_hi[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_per = 1'b0;
        prev_sync = 1'b0;
      end else begin
        if (sq) sq_total++;
        if (sync) begin
          sync_cnt++;
          chk("sync_width", int'(prev_sync), 0);
          if (in_per) finish_period();
          in_per = 1'b1;
          per_cyc = 1;
          for (int i = 0; i < 8; i++) slot_hi[i] = 0;
        end else if (in_per) begin
          if (busy) begin
            per_cyc++;
            if (sq) slot_hi[slot]++;
          end else begin
            finish_period();
            in_per = 1'b0;
          end
        end
        prev_sync = sync;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic signed [16:0] re, input logic signed [16:0] im, input logic last);
    int n;
    n = 0;
    amp_re = re;
    amp_im = im;
    amp_last = last;
    amp_valid = 1'b1;
    @(negedge clk);
    while (!amp_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!amp_ready) chk("word_accept_timeout", int'(amp_ready), 1);
    @(posedge clk);
    #1;
    amp_valid = 1'b0;
    amp_last = 1'b0;
  endtask

  task automatic load_frame(input vec_t v);
    for (int i = 0; i < 8; i++) send_word(v.re[i], v.im[i], i == 7);
  endtask

  task automatic wait_full();
    int n;
    n = 0;
    @(negedge clk);
    while (amp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_low_after_load", int'(amp_ready), 0);
    tick(3);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("period_ends", int'(busy), 0);
  endtask

  task automatic wait_sync(input string name, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!sync && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(sync), 1);
    #1;
  endtask

  int sc;
  int hold;
  int n;

  initial begin
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    // ~0.7071 in slots 0 and 1 -> 7 cycles each
    vecs[0].re[0] = 17'sd23170;
    vecs[0].re[1] = 17'sd23170;
    vecs[0].len[0] = 8'd7;
    vecs[0].len[1] = 8'd7;
    vecs[0].period = 16'd55;
    // -1.0 real and 0.5 imaginary
    vecs[1].re[3] = -17'sd32768;
    vecs[1].im[5] = 17'sd16384;
    vecs[1].len[3] = 8'd16;
    vecs[1].len[5] = 8'd4;
    vecs[1].period = 16'd61;
    // saturation of p
    vecs[2].re[2] = 17'sd32767;
    vecs[2].im[2] = 17'sd32767;
    vecs[2].len[2] = 8'd16;
    vecs[2].period = 16'd57;
    // all zero
    vecs[3].period = 16'd41;
    // mixed, including full-scale negative inputs and a nonzero p that floors to len 0
    vecs[4].re[0] = 17'sd16384;   vecs[4].len[0] = 8'd4;
    vecs[4].im[1] = -17'sd16384;  vecs[4].len[1] = 8'd4;
    vecs[4].re[2] = 17'sd16384;   vecs[4].im[2] = 17'sd16384;  vecs[4].len[2] = 8'd8;
    vecs[4].re[3] = 17'sd8192;    vecs[4].len[3] = 8'd1;
    vecs[4].re[4] = -17'sd65536;  vecs[4].len[4] = 8'd16;
    vecs[4].re[5] = -17'sd65536;  vecs[4].im[5] = -17'sd65536; vecs[4].len[5] = 8'd16;
    vecs[4].re[6] = 17'sd5792;    vecs[4].len[6] = 8'd0;
    vecs[4].re[7] = 17'sd11586;   vecs[4].len[7] = 8'd2;
    vecs[4].period = 16'd92;

    tick(3);
    chk("rst_sq", int'(sq), 0);
    chk("rst_sync", int'(sync), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_slot", int'(slot), 0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_amp_ready", int'(amp_ready), 1);

    pulse_start();
    tick(5);
    chk("start_without_frame", int'(busy), 0);

    for (int v = 0; v < 5; v++) begin
      load_frame(vecs[v]);
      wait_full();
      sb_q.push_back(mk(vecs[v]));
      pulse_start();
      wait_idle(300);
      tick(2);
      chk("sb_drained", sb_q.size(), 0);
      chk("no_frame_err", int'(frame_err), 0);
    end

    // early amp_last at idx 5
    for (int i = 0; i < 6; i++) send_word(vecs[0].re[i], vecs[0].im[i], i == 5);
    tick(3);
    chk("frame_err_set", int'(frame_err), 1);
    chk("partial_not_full", int'(amp_ready), 1);
    load_frame(vecs[1]);
    wait_full();
    chk("frame_err_sticky", int'(frame_err), 1);
    sb_q.push_back(mk(vecs[1]));
    pulse_start();
    wait_idle(300);
    tick(2);
    chk("sb_drained_err", sb_q.size(), 0);

    // continuous mode with a new frame loaded mid-period
    load_frame(vecs[0]);
    wait_full();
    sb_q.push_back(mk(vecs[0]));
    sb_q.push_back(mk(vecs[4]));
    @(posedge clk);
    #1 cont = 1'b1;
    wait_sync("cont_first_sync", 20);
    sc = sync_cnt;
    load_frame(vecs[4]);
    wait_full();
    chk("ready_low_until_swap", int'(amp_ready), 0);
    chk("busy_mid_period", int'(busy), 1);
    chk("no_early_swap", sync_cnt, sc);
    wait_sync("cont_second_sync", 100);
    chk("ready_low_at_sync", int'(amp_ready), 0);
    @(negedge clk);
    chk("ready_after_swap", int'(amp_ready), 1);
    @(posedge clk);
    #1 cont = 1'b0;
    wait_idle(300);
    tick(2);
    chk("sb_drained_cont", sb_q.size(), 0);

    // reset during the slot 2 pulse
    load_frame(vecs[4]);
    wait_full();
    sb_q.push_back(mk(vecs[4]));
    pulse_start();
    n = 0;
    @(negedge clk);
    while (!(sq && slot == 3'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_slot2_pulse", int'(sq && slot == 3'd2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sq", int'(sq), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_slot", int'(slot), 0);
    sb_q.delete();
    tick(2);
    rst_n = 1'b1;
    hold = sq_total;
    pulse_start();
    tick(20);
    chk("start_ignored_after_rst", int'(busy), 0);
    chk("no_sq_after_rst", sq_total, hold);
    chk("ready_after_rst", int'(amp_ready), 1);

    load_frame(vecs[2]);
    wait_full();
    sb_q.push_back(mk(vecs[2]));
    pulse_start();
    wait_idle(300);
    tick(2);
    chk("sb_drained_final", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
